// File: rtl/cdc_fifo_write_arbiter.sv
// Round-robin, burst-limited arbiter that shares the write port of a cdc_fifo
// among several requesters in the FIFO write-clock domain.
module cdc_fifo_write_arbiter #(
  parameter int DATA_WIDTH = 4,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic [DATA_WIDTH-1:0]         fifo_write_data,
  output logic                          fifo_write_increment,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [3:0]     beat_cnt_q, beat_cnt_d;
  logic [IDW-1:0] pick, idx;
  logic           found, owner_valid, xfer;

  // Descending scan so the lowest offset from rr_ptr wins; index wraps since NUM_REQ is 2^n.
  always_comb begin
    pick  = rr_ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = rr_ptr_q + IDW'(k);
      if (req_valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign owner_valid = req_valid[owner_q];
  assign xfer        = (state_q == GRANT) && owner_valid && !fifo_full;

  always_comb begin
    req_ready            = '0;
    fifo_write_data      = '0;
    fifo_write_increment = 1'b0;
    if (state_q == GRANT) begin
      req_ready[owner_q]   = !fifo_full;
      fifo_write_data      = req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
      fifo_write_increment = xfer;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          owner_d    = pick;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        // A withdrawn owner releases the grant; a full FIFO simply stalls with beat_cnt held.
        if (!owner_valid) begin
          state_d  = IDLE;
          rr_ptr_d = owner_q + IDW'(1);
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_q + 4'd1;
          if (beat_cnt_d == BURST_LAST) begin
            state_d  = IDLE;
            rr_ptr_d = owner_q + IDW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign grant_id = owner_q;
  assign busy     = (state_q == GRANT);

endmodule

// File: tb/tb_cdc_fifo_write_arbiter.sv
// Scoreboard bench for cdc_fifo_write_arbiter: requester streams feed the DUT,
// expected (grant_id, data) writes are queued and popped on each FIFO write.
module tb_cdc_fifo_write_arbiter;
  localparam int DW = 4;
  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0] req_ready;
  logic          fifo_full;
  logic [DW-1:0] fifo_write_data;
  logic          fifo_write_increment;
  logic [1:0]    grant_id;
  logic          busy;

  cdc_fifo_write_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_write_data(fifo_write_data),
    .fifo_write_increment(fifo_write_increment), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [3:0] srcq [NR][$];
  bit         en   [NR];
  logic [5:0] exp_q [$];

  logic          s_inc, s_busy;
  logic [1:0]    s_gid;
  logic [NR-1:0] s_ready;

  function automatic logic [3:0] mk(int id, int s);
    return 4'((id % 4) * 4 + (s % 4));
  endfunction

  task automatic load(int id, int n);
    for (int s = 0; s < n; s++) srcq[id].push_back(mk(id, s));
  endtask

  task automatic expect_words(int id, int first, int n);
    for (int s = first; s < first + n; s++) exp_q.push_back({2'(id), mk(id, s)});
  endtask

  task automatic refresh();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]        = en[i] && (srcq[i].size() > 0);
      req_data[i*DW +: DW] = (srcq[i].size() > 0) ? srcq[i][0] : 4'h0;
    end
  endtask

  // Called at a falling edge with inputs settled; advances one clock cycle.
  task automatic step();
    int xi;
    logic [5:0] e;
    #1;
    s_inc   = fifo_write_increment;
    s_busy  = busy;
    s_gid   = grant_id;
    s_ready = req_ready;
    total++;
    if (($countones(req_ready) > 1) || (fifo_write_increment && fifo_full)) begin
      bad++;
      $display("FAIL invariant t=%0t ready=%b inc=%b full=%b (need onehot0, no write while full)",
               $time, req_ready, fifo_write_increment, fifo_full);
    end
    xi = -1;
    for (int i = 0; i < NR; i++) if (req_valid[i] && req_ready[i]) xi = i;
    if (fifo_write_increment) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write t=%0t got gid=%0d data=%h, none expected",
                 $time, grant_id, fifo_write_data);
      end else begin
        e = exp_q.pop_front();
        if ({grant_id, fifo_write_data} !== e) begin
          bad++;
          $display("FAIL write_word t=%0t got gid=%0d data=%h need gid=%0d data=%h",
                   $time, grant_id, fifo_write_data, e[5:4], e[3:0]);
        end
      end
    end
    @(posedge clk);
    if (xi >= 0) void'(srcq[xi].pop_front());
    @(negedge clk);
    refresh();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    fifo_full = 1'b0;
    for (int i = 0; i < NR; i++) begin
      en[i] = 1'b0;
      srcq[i].delete();
    end
    exp_q.delete();
    refresh();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_drained(string name);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drained got %0d words still expected, need 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fifo_full = 1'b0;
    for (int i = 0; i < NR; i++) en[i] = 1'b0;
    refresh();
    @(negedge clk);
    #1;
    total++;
    if ({busy, req_ready, fifo_write_increment, fifo_write_data, grant_id} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got busy=%b ready=%b inc=%b data=%h gid=%0d need all 0",
               busy, req_ready, fifo_write_increment, fifo_write_data, grant_id);
    end
    do_reset();
    step();
    total++;
    if (s_busy !== 1'b0 || s_gid !== 2'd0) begin
      bad++;
      $display("FAIL reset_idle got busy=%b gid=%0d need 0 0", s_busy, s_gid);
    end
  endtask

  task automatic test_single_burst();
    bit e_inc [10] = '{0,1,1,1,1,0,1,1,0,0};
    bit e_bsy [10] = '{0,1,1,1,1,0,1,1,1,0};
    do_reset();
    load(0, 6);
    expect_words(0, 0, 6);
    en[0] = 1'b1;
    refresh();
    for (int c = 0; c < 10; c++) begin
      step();
      total++;
      if (s_inc !== e_inc[c] || s_busy !== e_bsy[c]) begin
        bad++;
        $display("FAIL single_burst c=%0d got inc=%b busy=%b need inc=%b busy=%b",
                 c, s_inc, s_busy, e_inc[c], e_bsy[c]);
      end
    end
    check_drained("single_burst");
  endtask

  task automatic test_round_robin();
    do_reset();
    load(0, 8);
    for (int i = 1; i < NR; i++) load(i, 4);
    for (int i = 0; i < NR; i++) expect_words(i, 0, 4);
    expect_words(0, 4, 4);
    for (int i = 0; i < NR; i++) en[i] = 1'b1;
    refresh();
    for (int c = 0; c < 26; c++) begin
      step();
      total++;
      if (s_inc !== ((c % 5 != 0) && (c < 25))) begin
        bad++;
        $display("FAIL round_robin_slot c=%0d got inc=%b need %b", c, s_inc, (c % 5 != 0) && (c < 25));
      end
    end
    check_drained("round_robin");
  endtask

  task automatic test_back_pressure();
    bit e_inc [14] = '{0,1,1,0,0,0,0,0,1,1,0,1,0,0};
    bit e_bsy [14] = '{0,1,1,1,1,1,1,1,1,1,0,1,1,0};
    do_reset();
    load(2, 5);
    expect_words(2, 0, 5);
    en[2] = 1'b1;
    refresh();
    for (int c = 0; c < 14; c++) begin
      fifo_full = (c >= 3) && (c <= 7);
      step();
      total++;
      if (s_inc !== e_inc[c] || s_busy !== e_bsy[c] || (fifo_full && s_ready !== '0)) begin
        bad++;
        $display("FAIL back_pressure c=%0d got inc=%b busy=%b ready=%b need inc=%b busy=%b",
                 c, s_inc, s_busy, s_ready, e_inc[c], e_bsy[c]);
      end
    end
    fifo_full = 1'b0;
    check_drained("back_pressure");
  endtask

  task automatic test_withdrawal();
    bit e_inc [11] = '{0,1,1,0,0,1,0,0,1,0,0};
    bit e_bsy [11] = '{0,1,1,1,0,1,1,0,1,1,0};
    do_reset();
    load(1, 2); load(3, 1); load(0, 1);
    expect_words(1, 0, 2); expect_words(3, 0, 1); expect_words(0, 0, 1);
    en[1] = 1'b1;
    refresh();
    for (int c = 0; c < 11; c++) begin
      step();
      if (c == 0) begin
        en[0] = 1'b1; en[3] = 1'b1;
        refresh();
      end
      total++;
      if (s_inc !== e_inc[c] || s_busy !== e_bsy[c]) begin
        bad++;
        $display("FAIL withdrawal c=%0d got inc=%b busy=%b need inc=%b busy=%b",
                 c, s_inc, s_busy, e_inc[c], e_bsy[c]);
      end
      if (c == 4) begin
        total++;
        if (s_gid !== 2'd1) begin
          bad++;
          $display("FAIL withdrawal_gid got %0d need 1", s_gid);
        end
      end
    end
    check_drained("withdrawal");
  endtask

  task automatic test_async_reset();
    do_reset();
    load(2, 4);
    expect_words(2, 0, 4);
    en[2] = 1'b1;
    refresh();
    repeat (6) step();
    load(3, 4);
    expect_words(3, 0, 4);
    en[3] = 1'b1;
    refresh();
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || req_ready !== '0 || fifo_write_increment !== 1'b0 || grant_id !== 2'd0) begin
      bad++;
      $display("FAIL async_reset got busy=%b ready=%b inc=%b gid=%0d need 0 0 0 0",
               busy, req_ready, fifo_write_increment, grant_id);
    end
    total++;
    if (exp_q.size() != 2) begin
      bad++;
      $display("FAIL async_reset_words got %0d unwritten need 2", exp_q.size());
    end
    for (int i = 0; i < NR; i++) begin
      en[i] = 1'b0;
      srcq[i].delete();
    end
    exp_q.delete();
    refresh();
    @(negedge clk);
    rst_n = 1'b1;
    load(1, 2); load(3, 2);
    expect_words(1, 0, 2); expect_words(3, 0, 2);
    en[1] = 1'b1; en[3] = 1'b1;
    refresh();
    repeat (9) step();
    check_drained("async_restart");
  endtask

  initial begin
    req_valid = '0;
    req_data  = '0;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_back_pressure();
    test_withdrawal();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdc_fifo_write_arbiter.md
# cdc_fifo_write_arbiter

Round-robin arbiter that shares the single write port of the `cdc_fifo` (DATA_WIDTH=4) between several write-clock-domain requesters. It sits entirely in the FIFO write-clock domain and drives the FIFO's `write_data` and `write_increment` directly. It observes the FIFO's `full` flag to apply back-pressure. Grants are burst-limited so that no requester can monopolise the FIFO.

## Interface
- `DATA_WIDTH`, default 4: FIFO word width.
- `NUM_REQ`, default 4: number of requesters; power of two, 2..8.
- `MAX_BURST`, default 4: maximum number of words accepted per grant; range 1..15.
- `clk`, input, 1: write-domain clock; the same net as FIFO `write_clock`.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req_valid`, input, NUM_REQ: requester i has a word available.
- `req_data`, input, NUM_REQ*DATA_WIDTH: word of requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`, output, NUM_REQ: the word of requester i is accepted this cycle.
- `fifo_full`, input, 1: FIFO `full` flag, already synchronous to `clk`.
- `fifo_write_data`, output, DATA_WIDTH: connects to FIFO `write_data`.
- `fifo_write_increment`, output, 1: connects to FIFO `write_increment`.
- `grant_id`, output, $clog2(NUM_REQ): index of the current or most recent owner.
- `busy`, output, 1: high while in the GRANT state.

## Operation
- Handshake is valid/ready. A transfer occurs on a rising `clk` edge where `req_valid[i] && req_ready[i]`.
- Once a requester raises `req_valid[i]`, it holds `req_valid[i]` and its data stable until the transfer. Dropping valid early is legal and is treated as a withdrawal.
- State machine: two states, IDLE and GRANT. Registers: `owner`, `rr_ptr`, `beat_cnt` (4 bits).
- IDLE:
  - All `req_ready` are 0, `fifo_write_increment` is 0, and `fifo_write_data` is 0.
  - If any `req_valid` is set, select the first set bit searching from `rr_ptr` upward with modulo-NUM_REQ wrap. Load `owner` with it, clear `beat_cnt`, and go to GRANT.
- GRANT:
  - `req_ready[owner] = !fifo_full`; all other ready bits are 0.
  - `fifo_write_data = req_data[owner]`.
  - `fifo_write_increment = req_valid[owner] && !fifo_full`, i.e. exactly the transfer condition.
  - `beat_cnt` increments on each transfer.
- Leaving GRANT (go to IDLE, with `rr_ptr <= owner+1 mod NUM_REQ`) happens when either:
  - a transfer makes `beat_cnt` reach MAX_BURST, or
  - `req_valid[owner]` is 0 in a GRANT cycle. No transfer occurs in that cycle.
- `fifo_full` stall: the arbiter stays in GRANT, `beat_cnt` holds, and there is no timeout. If the owner drops valid while stalled, the grant is released as above.
- `grant_id = owner`. `busy = (state == GRANT)`.
- Never more than one `req_ready` bit is high. A write is never issued while `fifo_full` is 1.

## Timing
- Asynchronous reset values: state IDLE, `owner` 0, `rr_ptr` 0, `beat_cnt` 0.
- Output values during reset: `grant_id` 0, `busy` 0, `req_ready` all 0, `fifo_write_increment` 0, `fifo_write_data` 0.
- Reset asserted mid-burst takes effect immediately. `fifo_write_increment` drops asynchronously and the in-flight word is not written.
- Arbitration latency: a request seen in IDLE on edge N gives GRANT from edge N; the first transfer can occur on edge N+1.
- Between consecutive grants there is exactly one IDLE cycle, a dead cycle with no FIFO write.
- Peak throughput: MAX_BURST words per MAX_BURST+1 cycles.
- The ready and write outputs are combinational from registered state, `fifo_full` and `req_valid[owner]`. There is no combinational path from `req_data` to anything but `fifo_write_data`.
- Fairness bound with NUM_REQ requesters all continuously valid: each is granted once every NUM_REQ grants, and waits at most (NUM_REQ-1)*(MAX_BURST+1) cycles with the FIFO not full.

## Test plan
- Reset, then one burst from a single requester: `req_valid`=0001 with 6 words queued, MAX_BURST=4, `fifo_full`=0.
  - Required: 4 writes on consecutive edges, then 1 IDLE cycle.
  - Then a regrant to requester 0: the search starts at `rr_ptr`=1 and wraps to 0.
  - Then 2 writes, valid drops, back to IDLE.
- Round robin with all four requesters continuously valid:
  - Required: `grant_id` sequence 0,1,2,3,0.
  - Each grant is exactly 4 writes, with one dead cycle between grants.
  - The data written matches each requester's stream in order.
- Back-pressure: hold `fifo_full`=1 for 5 cycles in the middle of requester 2's burst.
  - Required: `fifo_write_increment`=0 and `req_ready`=0 throughout, with `beat_cnt` held.
  - Required: the burst resumes and completes its remaining beats after `full` falls, with no word lost or duplicated.
- Withdrawal: requester 1 drops valid after 2 beats.
  - Required: the next cycle goes to IDLE with `rr_ptr`=2.
  - Required: a pending requester 3 is granted next, ahead of requester 0.
- Asynchronous reset: assert `rst_n`=0 mid-burst, between clock edges.
  - Required: `busy`, `req_ready` and `fifo_write_increment` go to 0 at once, and `grant_id` goes to 0.
  - Required: after release, arbitration restarts from `rr_ptr`=0.
- Throughout every test, a checker requires: `req_ready` is one-hot or zero, and there is no `fifo_write_increment` while `fifo_full`=1.
